// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter, binary product -> 4-digit packed BCD.
// Latency: BIN_WIDTH+1 clocks from the accepting start edge to the result-visible edge.
// Backpressure: start is accepted only while ready=1; start while busy is dropped, not queued.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   bin_in, start         - value to convert, sampled on the edge that accepts start
//   ready, done           - idle indicator, one-cycle pulse when a new result is written
//   BCD_code, valid_BCD   - held result ([15:12] thousands .. [3:0] units), sticky valid level
//   overflow              - last converted value exceeded 9999
// Build option: define BCD_SATURATE_EN to force BCD_code to 16'h9999 on overflow;
// otherwise the low four decimal digits (value mod 10000) are written.
module bin_to_bcd #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 start,
  output logic                 ready,
  output logic                 done,
  output logic [15:0]          BCD_code,
  output logic                 valid_BCD,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(BIN_WIDTH - 1);

  state_t               state;
  logic [19:0]          scratch;       // ten-thousands .. units nibbles
  logic [19:0]          corrected;
  logic [19:0]          scratch_next;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [3:0]           bit_cnt;
  logic [15:0]          result_code;
  logic                 result_ovf;

  // One double-dabble iteration: add-3 to every nibble >= 5 in parallel, then
  // shift left pulling in the next binary bit. The shift is written on the
  // whole corrected word; the ten-thousands nibble never exceeds 1 so nothing
  // meaningful falls off the top.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_next = (corrected << 1) | {19'd0, bin_sr[BIN_WIDTH-1]};
  end

  assign result_ovf = (scratch[19:16] != 4'd0);

`ifdef BCD_SATURATE_EN
  assign result_code = result_ovf ? 16'h9999 : scratch[15:0];
`else
  assign result_code = scratch[15:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scratch   <= '0;
      bin_sr    <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      BCD_code  <= 16'h0000;
      valid_BCD <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            bit_cnt <= '0;
            ready   <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          // Outputs only move here, so the display never sees a partial value.
          BCD_code  <= result_code;
          overflow  <= result_ovf;
          valid_BCD <= 1'b1;
          done      <= 1'b1;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] bin_in;
  logic         start;
  logic         ready;
  logic         done;
  logic [15:0]  BCD_code;
  logic         valid_BCD;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bin_to_bcd #(.BIN_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .start     (start),
    .ready     (ready),
    .done      (done),
    .BCD_code  (BCD_code),
    .valid_BCD (valid_BCD),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected display word from plain decimal arithmetic.
  function automatic logic [15:0] to_bcd(input int v);
    int d;
    d = v;
    if (v > 9999) begin
`ifdef BCD_SATURATE_EN
      d = 9999;
`else
      d = v % 10000;
`endif
    end
    return {4'(d / 1000 % 10), 4'(d / 100 % 10), 4'(d / 10 % 10), 4'(d % 10)};
  endfunction

  // Transaction-level model: a request is accepted when idle, and its result
  // appears W+1 edges later together with a single done cycle.
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;
  logic [15:0] m_bcd   = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_ovf   = 1'b0;
  int          busy_left = 0;
  int          pending   = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b1; m_done = 1'b0; m_bcd = 16'h0000;
      m_valid = 1'b0; m_ovf = 1'b0; busy_left = 0;
    end else begin
      m_done = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_bcd   = to_bcd(pending);
          m_ovf   = (pending > 9999);
          m_valid = 1'b1;
          m_done  = 1'b1;
          m_ready = 1'b1;
        end
      end else if (start) begin
        pending   = int'(bin_in);
        busy_left = W + 1;
        m_ready   = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",     16'(ready),     16'(m_ready));
      chk("done",      16'(done),      16'(m_done));
      chk("BCD_code",  BCD_code,       m_bcd);
      chk("valid_BCD", 16'(valid_BCD), 16'(m_valid));
      chk("overflow",  16'(overflow),  16'(m_ovf));
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within 40 cycles", tag);
    end
  endtask

  task automatic convert(input int v, input string tag);
    bin_in = W'(v);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = W'($urandom);   // must not disturb the conversion in flight
    wait_done(tag);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    chk("rst_ready", 16'(ready), 16'h0001);
    chk("rst_done",  16'(done),  16'h0000);
    chk("rst_valid", 16'(valid_BCD), 16'h0000);
    chk("rst_bcd",   BCD_code, 16'h0000);
    chk("rst_ovf",   16'(overflow), 16'h0000);

    // Zero: result exactly 15 edges after the accepting edge, done one cycle.
    bin_in = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("zero_ready_low", 16'(ready), 16'h0000);
    for (int j = 1; j < W + 1; j++) begin
      @(negedge clk);
      chk("zero_no_done_early", 16'(done), 16'h0000);
    end
    @(negedge clk);
    chk("zero_done",  16'(done), 16'h0001);
    chk("zero_valid", 16'(valid_BCD), 16'h0001);
    chk("zero_bcd",   BCD_code, 16'h0000);
    @(negedge clk);
    chk("zero_done_cleared", 16'(done), 16'h0000);

    convert(1234, "c1234");
    chk("lit_1234", BCD_code, 16'h1234);
    chk("lit_1234_ovf", 16'(overflow), 16'h0000);
    chk("model_1234", m_bcd, 16'h1234);

    convert(9999, "c9999");
    chk("lit_9999", BCD_code, 16'h9999);
    chk("lit_9999_ovf", 16'(overflow), 16'h0000);

    convert(12345, "c12345");
    chk("lit_12345_ovf", 16'(overflow), 16'h0001);
`ifdef BCD_SATURATE_EN
    chk("lit_12345", BCD_code, 16'h9999);
`else
    chk("lit_12345", BCD_code, 16'h2345);
    chk("model_12345", m_bcd, 16'h2345);
`endif

    convert(42, "c42");
    chk("lit_42", BCD_code, 16'h0042);
    chk("lit_42_ovf", 16'(overflow), 16'h0000);

    convert(10000, "c10000");
    chk("lit_10000_ovf", 16'(overflow), 16'h0001);
    convert(16383, "c16383");
    chk("lit_16383_ovf", 16'(overflow), 16'h0001);
`ifndef BCD_SATURATE_EN
    chk("lit_16383", BCD_code, 16'h6383);
`endif
    convert(8, "c8");
    chk("lit_8", BCD_code, 16'h0008);

    // Start while busy is dropped.
    bin_in = W'(500);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = W'(777);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("c500");
    chk("lit_500", BCD_code, 16'h0500);
    chk("lit_500_ready", 16'(ready), 16'h0001);

    // Back-to-back: start in the done cycle is accepted.
    bin_in = W'(777);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int j = 1; j < W + 1; j++) begin
      @(negedge clk);
      chk("b2b_hold_500", BCD_code, 16'h0500);
    end
    @(negedge clk);
    chk("b2b_done", 16'(done), 16'h0001);
    chk("lit_777",  BCD_code, 16'h0777);

    // Reset after the 7th shift of a 3000 conversion.
    @(negedge clk);
    convert(1234, "c1234b");
    bin_in = W'(3000);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_bcd",   BCD_code, 16'h0000);
    chk("midrst_valid", 16'(valid_BCD), 16'h0000);
    chk("midrst_ready", 16'(ready), 16'h0001);
    chk("midrst_ovf",   16'(overflow), 16'h0000);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("midrst_no_done", 16'(done), 16'h0000);
    end
    convert(3000, "c3000");
    chk("lit_3000", BCD_code, 16'h3000);
    chk("lit_3000_valid", 16'(valid_BCD), 16'h0001);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
